divisor_datapath: RTL and testbench
===================================

Name: divisor_datapath

Overview:
- Datapath for the 16-bit restoring shift-subtract divider.
- Sits directly downstream of the 3-bit counter-based divider controller. It consumes the controller's one-hot state vector Est[7:0] as its only control.
- Feeds back the two condition flags the controller branches on: Cont16NoCero and divisorNoCero.
- Produces quotient, remainder, done and div_by_zero.

Parameters:
- WIDTH, 16, operand, quotient and remainder width.
- CNT_W, 5, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  datapath clock; registers update on rising edge. The controller advances on the falling edge, so Est is stable at every rising edge.
- reset  input  1  asynchronous, active-low.
- Est  input  8  one-hot controller state; bit n = state n.
- dividend_in  input  WIDTH  dividend operand; sampled in state 1.
- divisor_in  input  WIDTH  divisor operand; sampled in state 1.
- divisorNoCero  output  1  combinational; 1 when divisor register B != 0.
- Cont16NoCero  output  1  combinational; 1 when iteration counter != 0.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- done  output  1  registered; result valid.
- div_by_zero  output  1  registered; last operation had divisor 0.

Behaviour:
- Internal registers: A (dividend/quotient shift register, WIDTH bits), R (partial remainder, WIDTH bits), B (divisor, WIDTH bits), cnt (CNT_W bits).
- Reset (reset=0, any time, including mid-operation): A, R, B, cnt, quotient, remainder, done and div_by_zero all clear to 0 immediately. Consequently divisorNoCero=0 and Cont16NoCero=0. The controller shares the same reset.
- Action at each rising clk edge, by the single Est bit set:
  - Est[0] idle: hold everything.
  - Est[1] load: A<=dividend_in; B<=divisor_in; done<=0; div_by_zero<=0. divisorNoCero reflects the new B before the next falling edge, where the controller samples it.
  - Est[2] init: R<=0; cnt<=WIDTH.
  - Est[3] shift: {R,A}<={R,A}<<1, with LSB 0.
  - Est[4] trial subtract: compute D = {1'b0,R} - {1'b0,B} in WIDTH+1 bits.
    - D[WIDTH]==0: R<=D[WIDTH-1:0]; A[0]<=1.
    - Otherwise: R unchanged; A[0]<=0.
  - Est[5] count: cnt<=cnt-1. Cont16NoCero is then sampled by the controller; nonzero loops back to state 3. Exactly WIDTH iterations of states 3-4-5 occur.
  - Est[6] finish: quotient<=A; remainder<=R; done<=1.
  - Est[7] hold/terminal:
    - If B==0 (arrived from state 1): quotient<=all ones; remainder<=A, i.e. the dividend; div_by_zero<=1; done<=1.
    - Otherwise: hold. The controller stays in state 7 while go=1 and returns to idle when go=0.
- Outputs hold through states 7 and 0 until the next state 1.
- cnt never wraps: it is only decremented in state 5 after being loaded with WIDTH in state 2.
- Latency, normal path: states 1, 2, 16×(3,4,5), 6. done rises at the rising edge inside the 51st clock period after the controller leaves state 0.
- Latency, divide-by-zero path: done rises inside the 2nd period, in state 7.
- Illegal Est (zero or multi-hot):
  - Hold all registers.
  - The bench flags it as an error.

Decomposition:
- Shared package holds:
  - state index constants EST_IDLE=0, EST_LOAD=1, EST_INIT=2, EST_SHIFT=3, EST_SUB=4, EST_CNT=5, EST_FIN=6, EST_HOLD=7;
  - default WIDTH=16 and CNT_W=5.
- One sub-module: cont_iter_carga, a loadable down-counter with load, decrement, async active-low reset and a nonzero flag. It provides cnt and Cont16NoCero.

Test Plan:
- Stimulus: controller plus datapath, 100/7, go pulse. Required: done=1 on the 51st period; quotient=14, remainder=2, div_by_zero=0; exactly 16 visits to state 5.
- Stimulus: 0xFFFF/0x0001. Required: quotient=0xFFFF, remainder=0x0000.
- Stimulus: 3/10. Required: quotient=0, remainder=3; every state-4 visit leaves A[0]=0.
- Stimulus: 5/0. Required: controller goes 1 -> 7; div_by_zero=1, quotient=0xFFFF, remainder=5, done=1 in the 2nd period; outputs stable while go=1.
- Stimulus: reset pulled low during iteration 5 of 1000/3. Required: all outputs 0 at once; after release, a new 1000/3 gives quotient=333, remainder=1.
- Stimulus: back-to-back 0xABCD/0x0012 then 0x0012/0xABCD, with go released between. Required: first quotient=0x098B, remainder=0x0007; done drops in state 1 of the second operation; second gives quotient=0, remainder=0x0012.

Source files
------------

// File: rtl/divisor_datapath_pkg.sv
// Shared definitions for the restoring divider datapath: state indices of the
// one-hot controller vector, default sizes and the Est decoder.
package divisor_datapath_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [2:0] {
    EST_IDLE  = 3'd0,
    EST_LOAD  = 3'd1,
    EST_INIT  = 3'd2,
    EST_SHIFT = 3'd3,
    EST_SUB   = 3'd4,
    EST_CNT   = 3'd5,
    EST_FIN   = 3'd6,
    EST_HOLD  = 3'd7
  } est_idx_e;

  // One strobe per active controller state; idle has no action of its own.
  typedef struct packed {
    logic load;
    logic init;
    logic shift;
    logic sub;
    logic cnt;
    logic fin;
    logic hold;
  } ctl_t;

  function automatic logic est_is_onehot(input logic [7:0] est);
    return (est != 8'd0) && ((est & (est - 8'd1)) == 8'd0);
  endfunction

  // Zero or multi-hot Est decodes to no strobes, so every register holds.
  function automatic ctl_t decode_est(input logic [7:0] est);
    ctl_t c;
    // NOTE: every field gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is implied.
    c = '0;
    if (est_is_onehot(est)) begin
      c.load  = est[EST_LOAD];
      c.init  = est[EST_INIT];
      c.shift = est[EST_SHIFT];
      c.sub   = est[EST_SUB];
      c.cnt   = est[EST_CNT];
      c.fin   = est[EST_FIN];
      c.hold  = est[EST_HOLD];
    end
    return c;
  endfunction

endpackage

// File: rtl/divisor_datapath_cont_iter_carga.sv
// Loadable down-counter for the divider iteration count, with a nonzero flag
// that the controller uses to decide whether to loop again.
module cont_iter_carga
  import divisor_datapath_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_nonzero
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: the reset is asynchronous and active-low, so it sits in the
  // sensitivity list and wins over every other branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state is written with <= so every register samples
      // the pre-edge values of its neighbours.
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_nonzero = (r_cnt != '0);

endmodule

// File: rtl/divisor_datapath.sv
// Datapath of the 16-bit restoring shift-subtract divider, driven only by the
// controller's one-hot state vector Est and feeding back its branch flags.
module divisor_datapath
  import divisor_datapath_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       Est,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             divisorNoCero,
  output logic             Cont16NoCero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             div_by_zero
);

  ctl_t             w_ctl;
  logic [WIDTH:0]   w_diff;
  logic             w_b_zero;
  logic             w_cnt_nz;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_done;
  logic             r_dbz;

  assign w_ctl    = decode_est(Est);
  // The extra top bit is the borrow: set means R < B and the trial fails.
  assign w_diff   = {1'b0, r_r} - {1'b0, r_b};
  assign w_b_zero = (r_b == '0);

  cont_iter_carga #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_ctl.init),
    .i_dec      (w_ctl.cnt),
    .i_load_val (CNT_W'(WIDTH)),
    .o_nonzero  (w_cnt_nz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= '0;
      r_r <= '0;
      r_b <= '0;
    end else begin
      if (w_ctl.load) begin
        r_a <= dividend_in;
        r_b <= divisor_in;
      end
      if (w_ctl.init) begin
        r_r <= '0;
      end
      if (w_ctl.shift) begin
        {r_r, r_a} <= {r_r[WIDTH-2:0], r_a, 1'b0};
      end
      if (w_ctl.sub) begin
        if (!w_diff[WIDTH]) begin
          r_r    <= w_diff[WIDTH-1:0];
          r_a[0] <= 1'b1;
        end else begin
          r_a[0] <= 1'b0;
        end
      end
    end
  end

  // Result registers hold through hold/idle until the next load clears done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      if (w_ctl.load) begin
        r_done <= 1'b0;
        r_dbz  <= 1'b0;
      end
      if (w_ctl.fin) begin
        r_quot <= r_a;
        r_rem  <= r_r;
        r_done <= 1'b1;
      end
      // A zero divisor skips the iterations; A still holds the dividend.
      if (w_ctl.hold && w_b_zero) begin
        r_quot <= '1;
        r_rem  <= r_a;
        r_dbz  <= 1'b1;
        r_done <= 1'b1;
      end
    end
  end

  assign divisorNoCero = !w_b_zero;
  assign Cont16NoCero  = w_cnt_nz;
  assign quotient      = r_quot;
  assign remainder     = r_rem;
  assign done          = r_done;
  assign div_by_zero   = r_dbz;

endmodule

// File: tb/tb_divisor_datapath.sv
// Bench for divisor_datapath: a falling-edge controller model drives Est, a
// vector table covers the main operations, hand sequences cover the corners.
module tb_divisor_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  Est = 8'h01;
  logic [15:0] dividend_in = '0;
  logic [15:0] divisor_in = '0;
  logic        divisorNoCero;
  logic        Cont16NoCero;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        done;
  logic        div_by_zero;

  int st = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          done_p;
    int          v5;
    bit          chk_a0;
  } vec_t;

  vec_t vecs[8];

  divisor_datapath dut (
    .clk           (clk),
    .reset         (reset),
    .Est           (Est),
    .dividend_in   (dividend_in),
    .divisor_in    (divisor_in),
    .divisorNoCero (divisorNoCero),
    .Cont16NoCero  (Cont16NoCero),
    .quotient      (quotient),
    .remainder     (remainder),
    .done          (done),
    .div_by_zero   (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Controller model: branches on the flags as seen at the falling edge.
  function automatic int next_state(input int s);
    case (s)
      0:       return go ? 1 : 0;
      1:       return divisorNoCero ? 2 : 7;
      2:       return 3;
      3:       return 4;
      4:       return 5;
      5:       return Cont16NoCero ? 3 : 6;
      6:       return 7;
      7:       return go ? 7 : 0;
      default: return 0;
    endcase
  endfunction

  // Advance the controller at the falling edge, then sample 1 after rising.
  task automatic step();
    @(negedge clk);
    st  = next_state(st);
    Est = 8'd1 << st;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int period, v5, a0bad, done_p;
    logic done_p1;
    period = 0; v5 = 0; a0bad = 0; done_p = 0; done_p1 = 1'bx;
    dividend_in = v.a;
    divisor_in  = v.b;
    go = 1'b1;
    do begin
      step();
      period++;
      if (period == 1) done_p1 = done;
      if (st == 5) v5++;
      if (st == 4 && dut.r_a[0]) a0bad++;
      if (done && done_p == 0) done_p = period;
    end while (st != 7 && period < 80);
    check({tag, " end_state"}, st, 7);
    check({tag, " quotient"}, quotient, v.q);
    check({tag, " remainder"}, remainder, v.r);
    check({tag, " div_by_zero"}, div_by_zero, v.dbz);
    check({tag, " done"}, done, 1'b1);
    check({tag, " done_period"}, done_p, v.done_p);
    check({tag, " state5_visits"}, v5, v.v5);
    check({tag, " done_low_in_load"}, done_p1, 1'b0);
    if (v.chk_a0) check({tag, " a0_after_sub"}, a0bad, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check({tag, " hold7_state"}, st, 7);
      check({tag, " hold7_out"}, {quotient, remainder, done, div_by_zero}, {v.q, v.r, 1'b1, v.dbz});
    end
    go = 1'b0;
    step();
    check({tag, " idle_state"}, st, 0);
    check({tag, " idle_out"}, {quotient, remainder, done, div_by_zero}, {v.q, v.r, 1'b1, v.dbz});
  endtask

  initial begin
    vec_t rv;
    int v5, guard;
    logic [33:0] snap;

    //         a         b         q         r         dbz   p   v5  a0
    vecs[0] = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 51, 16, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 51, 16, 1'b0};
    vecs[2] = '{16'd3,    16'd10,   16'd0,    16'd3,    1'b0, 51, 16, 1'b1};
    vecs[3] = '{16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1, 2,  0,  1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 51, 16, 1'b0};
    vecs[5] = '{16'hABCD, 16'h0012, 16'h098B, 16'h0007, 1'b0, 51, 16, 1'b0};
    vecs[6] = '{16'h0012, 16'hABCD, 16'h0000, 16'h0012, 1'b0, 51, 16, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 2,  0,  1'b0};

    #12;
    check("reset quotient", quotient, 16'h0);
    check("reset remainder", remainder, 16'h0);
    check("reset done", done, 1'b0);
    check("reset div_by_zero", div_by_zero, 1'b0);
    check("reset flags", {divisorNoCero, Cont16NoCero}, 2'b00);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted during the 5th iteration of 1000/3.
    dividend_in = 16'd1000;
    divisor_in  = 16'd3;
    go = 1'b1;
    v5 = 0; guard = 0;
    do begin
      step();
      guard++;
      if (st == 5) v5++;
    end while (!(st == 4 && v5 == 4) && guard < 80);
    check("abort reached_iter5", v5, 4);
    check("abort flags_before", {divisorNoCero, Cont16NoCero}, 2'b11);
    #2;
    reset = 1'b0;
    #1;
    check("abort quotient", quotient, 16'h0);
    check("abort remainder", remainder, 16'h0);
    check("abort done_dbz", {done, div_by_zero}, 2'b00);
    check("abort flags", {divisorNoCero, Cont16NoCero}, 2'b00);
    st = 0;
    Est = 8'h01;
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    rv = '{16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 51, 16, 1'b0};
    run_vec(rv, "rerun");

    // Illegal Est patterns must leave every register untouched.
    dividend_in = 16'h5555;
    divisor_in  = 16'h0000;
    snap = {quotient, remainder, done, div_by_zero};
    @(negedge clk); Est = 8'h00; @(posedge clk); #1;
    check("illegal_zero out", {quotient, remainder, done, div_by_zero}, snap);
    check("illegal_zero flags", {divisorNoCero, Cont16NoCero}, 2'b10);
    @(negedge clk); Est = 8'h48; @(posedge clk); #1;
    check("illegal_48 out", {quotient, remainder, done, div_by_zero}, snap);
    check("illegal_48 flags", {divisorNoCero, Cont16NoCero}, 2'b10);
    @(negedge clk); Est = 8'h06; @(posedge clk); #1;
    check("illegal_06 out", {quotient, remainder, done, div_by_zero}, snap);
    check("illegal_06 flags", {divisorNoCero, Cont16NoCero}, 2'b10);
    @(negedge clk); Est = 8'h01; st = 0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
